// File: rtl/seg_pkg.sv
// Shared types and constants for the 4-digit scanned 7-segment driver.
// Holds digit slot indices, conversion FSM states and the segment encoder.
package seg_pkg;

    localparam logic [1:0] DIG_LO_U = 2'd0;
    localparam logic [1:0] DIG_LO_T = 2'd1;
    localparam logic [1:0] DIG_HI_U = 2'd2;
    localparam logic [1:0] DIG_HI_T = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CONV   = 2'd1,
        ST_COMMIT = 2'd2
    } conv_state_t;

    localparam logic [6:0] SEG_OFF = 7'h00;
    localparam logic [6:0] SEG_0   = 7'h3F;
    localparam logic [6:0] SEG_1   = 7'h06;
    localparam logic [6:0] SEG_2   = 7'h5B;
    localparam logic [6:0] SEG_3   = 7'h4F;
    localparam logic [6:0] SEG_4   = 7'h66;
    localparam logic [6:0] SEG_5   = 7'h6D;
    localparam logic [6:0] SEG_6   = 7'h7D;
    localparam logic [6:0] SEG_7   = 7'h07;
    localparam logic [6:0] SEG_8   = 7'h7F;
    localparam logic [6:0] SEG_9   = 7'h6F;

    // Active-high {g,f,e,d,c,b,a}; non-decimal codes go dark.
    function automatic logic [6:0] seg_encode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_OFF;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seg_scan_driver_bcd.sv
// Sequential double-dabble converter for a 6-bit binary field.
// Load with start, then six step pulses leave the 8-bit BCD result on bcd.
module bin6_to_bcd (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       step,
    input  logic [5:0] bin,
    output logic [7:0] bcd
);

    logic [5:0] shift_q;
    logic [7:0] acc_q;
    logic [3:0] adj_u;

    // Tens never exceeds 3 before a shift for 6-bit inputs, so only units is corrected.
    always_comb begin
        adj_u = acc_q[3:0];
        if (acc_q[3:0] >= 4'd5) adj_u = acc_q[3:0] + 4'd3;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            shift_q <= '0;
            acc_q   <= '0;
        end else if (start) begin
            shift_q <= bin;
            acc_q   <= '0;
        end else if (step) begin
            shift_q <= {shift_q[4:0], 1'b0};
            acc_q   <= {acc_q[6:4], adj_u, shift_q[5]};
        end
    end

    assign bcd = acc_q;

endmodule

// File: rtl/seg_scan_driver.sv
// 4-digit multiplexed 7-segment driver: converts two 6-bit fields to BCD,
// commits them atomically and scans the digits with blanking between slots.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int SCAN_DIV       = 64,
    parameter int BLANK_CYCLES   = 4,
    parameter bit SEG_ACTIVE_LOW = 1'b0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [11:0] data_show,
    input  logic [3:0]  byte_control,
    input  logic        colon,
    output logic [6:0]  segment,
    output logic        dp,
    output logic [3:0]  digit_sel,
    output logic        busy
);

    localparam int PW = $clog2(SCAN_DIV);

    conv_state_t state_q, state_d;
    logic [11:0] src_q;
    logic [2:0]  cnt_q;
    logic        start, step, commit;
    logic [7:0]  bcd_hi, bcd_lo;
    logic [7:0]  disp_hi_q, disp_lo_q;

    always_ff @(posedge clock) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (data_show != src_q) state_d = ST_CONV;
            ST_CONV:   if (cnt_q == 3'd5) state_d = ST_COMMIT;
            ST_COMMIT: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        start  = (state_q == ST_IDLE) && (data_show != src_q);
        step   = (state_q == ST_CONV);
        commit = (state_q == ST_COMMIT);
        busy   = (state_q != ST_IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            src_q     <= '0;
            cnt_q     <= '0;
            disp_hi_q <= '0;
            disp_lo_q <= '0;
        end else begin
            if (start) src_q <= data_show;
            if (start)     cnt_q <= '0;
            else if (step) cnt_q <= cnt_q + 3'd1;
            if (commit) begin
                disp_hi_q <= bcd_hi;
                disp_lo_q <= bcd_lo;
            end
        end
    end

    bin6_to_bcd u_bcd_hi (
        .clock (clock),
        .reset (reset),
        .start (start),
        .step  (step),
        .bin   (data_show[11:6]),
        .bcd   (bcd_hi)
    );

    bin6_to_bcd u_bcd_lo (
        .clock (clock),
        .reset (reset),
        .start (start),
        .step  (step),
        .bin   (data_show[5:0]),
        .bcd   (bcd_lo)
    );

    logic [PW-1:0] presc_q;
    logic [1:0]    idx_q;
    logic          blank;
    logic [3:0]    cur_digit;
    logic [6:0]    seg_d;
    logic          dp_d;
    logic [3:0]    sel_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            presc_q <= '0;
            idx_q   <= '0;
        end else if (presc_q == PW'(SCAN_DIV - 1)) begin
            presc_q <= '0;
            idx_q   <= idx_q + 2'd1;
        end else begin
            presc_q <= presc_q + 1'b1;
        end
    end

    always_comb begin
        blank = (presc_q < PW'(BLANK_CYCLES));
        case (idx_q)
            DIG_LO_U: cur_digit = disp_lo_q[3:0];
            DIG_LO_T: cur_digit = disp_lo_q[7:4];
            DIG_HI_U: cur_digit = disp_hi_q[3:0];
            DIG_HI_T: cur_digit = disp_hi_q[7:4];
            default:  cur_digit = 4'd0;
        endcase
        sel_d = blank ? 4'd0 : ((4'd1 << idx_q) & byte_control);
        seg_d = SEG_OFF;
        if (!blank && byte_control[idx_q]) seg_d = seg_encode(cur_digit);
        dp_d = colon && (idx_q == DIG_HI_U) && !blank && byte_control[DIG_HI_U];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            segment   <= {7{SEG_ACTIVE_LOW}};
            dp        <= SEG_ACTIVE_LOW;
            digit_sel <= '0;
        end else begin
            segment   <= seg_d ^ {7{SEG_ACTIVE_LOW}};
            dp        <= dp_d ^ SEG_ACTIVE_LOW;
            digit_sel <= sel_d;
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Randomised self-checking bench for seg_scan_driver against a
// cycle-level behavioural model of the display and conversion timing.
module tb_seg_scan_driver;

    localparam int SCAN_DIV       = 64;
    localparam int BLANK_CYCLES   = 4;
    localparam bit SEG_ACTIVE_LOW = 1'b0;

    logic        clock = 1'b0;
    logic        reset;
    logic [11:0] data_show;
    logic [3:0]  byte_control;
    logic        colon;
    logic [6:0]  segment;
    logic        dp;
    logic [3:0]  digit_sel;
    logic        busy;

    seg_scan_driver #(
        .SCAN_DIV       (SCAN_DIV),
        .BLANK_CYCLES   (BLANK_CYCLES),
        .SEG_ACTIVE_LOW (SEG_ACTIVE_LOW)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .data_show    (data_show),
        .byte_control (byte_control),
        .colon        (colon),
        .segment      (segment),
        .dp           (dp),
        .digit_sel    (digit_sel),
        .busy         (busy)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    // Model: scan time since reset, shown value, pending conversion.
    int          m_scan;
    logic [11:0] m_src, m_disp;
    int          m_left;
    logic [6:0]  e_seg;
    logic        e_dp;
    logic [3:0]  e_sel;

    logic [3:0]  seen_mask;
    logic [6:0]  seg_seen [4];
    int          dp_cnt, dp_bad, busy_cnt;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        int pre, idx, fv, dv;
        bit blank;
        if (reset) begin
            e_seg  = '0;
            e_dp   = 1'b0;
            e_sel  = '0;
            m_scan = 0;
            m_src  = '0;
            m_disp = '0;
            m_left = 0;
        end else begin
            pre   = m_scan % SCAN_DIV;
            idx   = (m_scan / SCAN_DIV) % 4;
            blank = pre < BLANK_CYCLES;
            fv    = (idx >= 2) ? int'(m_disp[11:6]) : int'(m_disp[5:0]);
            dv    = (idx % 2 == 1) ? fv / 10 : fv % 10;
            e_sel = (!blank && byte_control[idx]) ? 4'(1 << idx) : 4'd0;
            e_seg = (!blank && byte_control[idx]) ? seg_tab[dv] : 7'h00;
            e_dp  = colon && idx == 2 && !blank && byte_control[2];
            m_scan++;
            if (m_left == 0) begin
                if (data_show != m_src) begin
                    m_src  = data_show;
                    m_left = 7;
                end
            end else begin
                m_left--;
                if (m_left == 0) m_disp = m_src;
            end
        end
        @(posedge clock);
        #1;
        check_eq("busy", int'(busy), int'(m_left != 0));
        check_eq("digit_sel", int'(digit_sel), int'(e_sel));
        check_eq("segment", int'(segment), int'(e_seg ^ {7{SEG_ACTIVE_LOW}}));
        check_eq("dp", int'(dp), int'(e_dp ^ SEG_ACTIVE_LOW));
        seen_mask |= digit_sel;
        for (int i = 0; i < 4; i++)
            if (digit_sel == 4'(1 << i)) seg_seen[i] = segment;
        dp_cnt   += int'(dp);
        busy_cnt += int'(busy);
        if (dp && digit_sel != 4'b0100) dp_bad++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clear_stats();
        seen_mask = '0;
        for (int i = 0; i < 4; i++) seg_seen[i] = 7'h00;
        dp_cnt   = 0;
        dp_bad   = 0;
        busy_cnt = 0;
    endtask

    initial begin
        reset        = 1'b1;
        data_show    = '0;
        byte_control = 4'hF;
        colon        = 1'b0;
        clear_stats();
        #1;
        run(3);
        check_eq("rst_sel", int'(digit_sel), 0);
        check_eq("rst_busy", int'(busy), 0);
        reset = 1'b0;
        run(BLANK_CYCLES + 1);
        check_eq("first_sel", int'(digit_sel), 1);
        check_eq("first_seg", int'(segment), 'h3F);

        data_show = {6'd23, 6'd59};
        clear_stats();
        run(12);
        check_eq("busy_len_a", busy_cnt, 7);
        clear_stats();
        run(4 * SCAN_DIV + 8);
        check_eq("a_d0", int'(seg_seen[0]), 'h6F);
        check_eq("a_d1", int'(seg_seen[1]), 'h6D);
        check_eq("a_d2", int'(seg_seen[2]), 'h4F);
        check_eq("a_d3", int'(seg_seen[3]), 'h5B);

        data_show = {6'd0, 6'd7};
        run(3);
        data_show = {6'd12, 6'd34};
        check_eq("lww_busy", int'(busy), 1);
        run(30);
        clear_stats();
        run(4 * SCAN_DIV + 8);
        check_eq("b_busy", busy_cnt, 0);
        check_eq("b_d0", int'(seg_seen[0]), 'h66);
        check_eq("b_d1", int'(seg_seen[1]), 'h4F);
        check_eq("b_d2", int'(seg_seen[2]), 'h5B);
        check_eq("b_d3", int'(seg_seen[3]), 'h06);

        byte_control = 4'b0011;
        data_show    = {6'd0, 6'd63};
        run(20);
        clear_stats();
        run(4 * SCAN_DIV + 8);
        check_eq("c_mask_hi", int'(seen_mask[3:2]), 0);
        check_eq("c_d1", int'(seg_seen[1]), 'h7D);
        check_eq("c_d0", int'(seg_seen[0]), 'h4F);

        byte_control = 4'hF;
        colon        = 1'b1;
        run(10);
        clear_stats();
        run(4 * SCAN_DIV);
        check_eq("dp_count", dp_cnt, SCAN_DIV - BLANK_CYCLES);
        check_eq("dp_misplaced", dp_bad, 0);
        colon = 1'b0;

        data_show = {6'd45, 6'd17};
        run(4);
        reset = 1'b1;
        run(1);
        check_eq("abort_busy", int'(busy), 0);
        reset = 1'b0;
        clear_stats();
        run(12);
        check_eq("busy_len_r", busy_cnt, 7);
        run(4 * SCAN_DIV + 8);

        for (int it = 0; it < 60; it++) begin
            data_show    = 12'($urandom);
            byte_control = 4'($urandom);
            colon        = 1'($urandom);
            if ($urandom_range(0, 9) == 0) begin
                reset = 1'b1;
                run($urandom_range(1, 2));
                reset = 1'b0;
            end
            run($urandom_range(1, 40));
        end
        run(4 * SCAN_DIV);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
